// File: rtl/slave_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : slave_read_responder
// Purpose  : AXI-style read-channel slave backed by a word-addressed memory.
//            Accepts one AR request at a time and returns arlen+1 R beats
//            (FIXED / INCR / WRAP addressing), with SLVERR for unsupported
//            requests and DECERR for beats outside the memory window.
//            A backdoor write port preloads / updates memory at any time.
// Ports    : sys_clk, sys_rstn          - clock, synchronous active-low reset
//            arid/araddr/arlen/arsize/arburst/arvalid, arready - AR channel
//            rid/rdata/rresp/rlast/rvalid, rready             - R channel
//            mem_we/mem_waddr/mem_wdata - backdoor memory write
// Revision : 1.0 - initial release
// ============================================================================
module slave_read_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int RESP_WIDTH = 2,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         sys_clk,
    input  logic                         sys_rstn,
    // AR channel
    input  logic [ID_WIDTH-1:0]          arid,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    // R channel
    output logic [ID_WIDTH-1:0]          rid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [RESP_WIDTH-1:0]        rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    // Backdoor memory write
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);

    localparam int WORD_AW = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic                    ar_hs;       // AR accepted this cycle
    logic                    beat_adv;    // non-final beat accepted, load next
    logic                    burst_done;  // final beat accepted

    // Burst context captured at the AR handshake
    logic [ADDR_WIDTH-1:0]   cur_addr;    // address of the beat currently on R
    logic [7:0]              lat_len;
    logic [2:0]              lat_size;
    logic [1:0]              lat_burst;
    logic                    lat_err;     // whole burst answers SLVERR
    logic [7:0]              beat_cnt;

    // Next-beat address generation and beat load values
    logic [ADDR_WIDTH-1:0]   stride;
    logic [ADDR_WIDTH-1:0]   wrap_mask;
    logic [ADDR_WIDTH-1:0]   incr_addr;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [ADDR_WIDTH-1:0]   load_addr;
    logic                    ar_err;
    logic                    load_err;
    logic                    load_oob;
    logic                    load_last;
    logic [WORD_AW-1:0]      load_idx;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        arready    = 1'b0;
        rvalid     = 1'b0;
        ar_hs      = 1'b0;
        beat_adv   = 1'b0;
        burst_done = 1'b0;
        case (state)
            IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    ar_hs     = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                // A beat is always presented while in BURST: the first one is
                // loaded at the handshake edge, later ones on each acceptance.
                rvalid = 1'b1;
                if (rready) begin
                    if (rlast) begin
                        burst_done = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        beat_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beat address and response computation
    // ------------------------------------------------------------------
    always_comb begin
        stride    = ADDR_WIDTH'(1) << lat_size;
        // WRAP region is (len+1) transfers long and naturally aligned; keep the
        // region base bits and let only the in-region offset advance.
        wrap_mask = ((ADDR_WIDTH'(lat_len) + ADDR_WIDTH'(1)) << lat_size) - ADDR_WIDTH'(1);
        incr_addr = cur_addr + stride;
        case (lat_burst)
            BURST_FIXED: addr_nxt = cur_addr;
            BURST_WRAP:  addr_nxt = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     addr_nxt = incr_addr;
        endcase

        ar_err = (arsize > 3'd2) ||
                 (arburst == BURST_RSVD) ||
                 ((arburst == BURST_WRAP) &&
                  !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15)));

        load_addr = ar_hs ? araddr : addr_nxt;
        load_err  = ar_hs ? ar_err : lat_err;
        load_last = ar_hs ? (arlen == 8'd0) : ((beat_cnt + 8'd1) == lat_len);
        load_idx  = load_addr[WORD_AW+1:2];
        load_oob  = |load_addr[ADDR_WIDTH-1:WORD_AW+2];
    end

    // Byte-lane bits do not select anything: narrow beats return the full word.
    logic unused_lane_bits;
    assign unused_lane_bits = &{1'b0, load_addr[1:0]};

    // ------------------------------------------------------------------
    // Burst context and R-channel output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            rid       <= '0;
            rdata     <= '0;
            rresp     <= '0;
            rlast     <= 1'b0;
            beat_cnt  <= '0;
            cur_addr  <= '0;
            lat_len   <= '0;
            lat_size  <= '0;
            lat_burst <= '0;
            lat_err   <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid       <= arid;
                cur_addr  <= araddr;
                lat_len   <= arlen;
                lat_size  <= arsize;
                lat_burst <= arburst;
                lat_err   <= ar_err;
                beat_cnt  <= '0;
            end else if (beat_adv) begin
                cur_addr  <= addr_nxt;
                beat_cnt  <= beat_cnt + 8'd1;
            end

            // Output registers only move when a new beat is loaded, which keeps
            // them stable across any number of rready=0 cycles.
            if (ar_hs || beat_adv) begin
                rlast <= load_last;
                if (load_err) begin
                    rresp <= RESP_SLVERR;
                    rdata <= '0;
                end else if (load_oob) begin
                    rresp <= RESP_DECERR;
                    rdata <= '0;
                end else begin
                    rresp <= RESP_OKAY;
                    rdata <= mem[load_idx];
                end
            end else if (burst_done) begin
                rlast <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing memory: not reset, written regardless of FSM state. A write to
    // the word being loaded on the same edge is not seen by that beat.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slave_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_read_responder
// Purpose  : Self-checking bench for slave_read_responder: a table of directed
//            bursts with hand-derived expectations, hand-written multi-cycle
//            sequences (stall, same-cycle write, mid-burst reset) and random
//            bursts checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_read_responder;

    localparam int MEM_BYTES = 256 * 4;

    logic        clk;
    logic        sys_rstn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;

    slave_read_responder dut (
        .sys_clk   (clk),
        .sys_rstn  (sys_rstn),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [256];

    logic [31:0] got_data [$];
    logic [1:0]  got_resp [$];
    logic [3:0]  got_id   [$];
    logic        got_last [$];

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        int               nbeats;
        logic [3:0][31:0] data;
        logic [3:0][1:0]  resp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                                input logic [1:0] bt, input logic [3:0] id, input int n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.addr = a; v.len = len; v.size = sz; v.burst = bt; v.id = id; v.nbeats = n;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3;
        return v;
    endfunction

    // Reference model: beat i of a burst, straight from the addressing rules.
    function automatic void exp_beat(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] sz, input logic [1:0] bt, input int i,
                                     output logic [31:0] d, output logic [1:0] r);
        logic [31:0] stride, span, base, addr;
        logic        slv;
        stride = 32'd1 << sz;
        case (bt)
            2'b01:   addr = a + 32'(i) * stride;
            2'b10: begin
                span = (32'(len) + 32'd1) * stride;
                base = a - (a % span);
                addr = base + ((a - base + 32'(i) * stride) % span);
            end
            default: addr = a;
        endcase
        slv = (sz > 3'd2) || (bt == 2'b11) ||
              (bt == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        if (slv) begin
            r = 2'b10; d = 32'd0;
        end else if (addr >= 32'(MEM_BYTES)) begin
            r = 2'b11; d = 32'd0;
        end else begin
            r = 2'b00; d = model_mem[addr / 4];
        end
    endfunction

    // Issue one AR and collect every R beat; mode 0 = always ready,
    // 1 = rready pattern 1,0,0 repeating, 2 = random rready.
    task automatic do_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [3:0] id, input int mode);
        logic [38:0] snap;
        logic        stalled;
        logic        done;
        got_data.delete(); got_resp.delete(); got_id.delete(); got_last.delete();
        @(negedge clk);
        araddr = a; arlen = len; arsize = sz; arburst = bt; arid = id;
        arvalid = 1'b1; rready = 1'b0;
        chk("arready_idle", arready, 1);
        chk("rvalid_in_hs_cycle", rvalid, 0);
        @(negedge clk);
        arvalid = 1'b0;
        chk("first_beat_latency", rvalid, 1);
        stalled = 1'b0; done = 1'b0; snap = '0;
        for (int c = 0; c < 600 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (!rvalid) begin
                chk("rvalid_dropped_mid_burst", rvalid, 1);
                break;
            end
            if (stalled) chk("stall_stable", {rid, rdata, rresp, rlast}, {25'd0, snap});
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (c % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rready) begin
                got_data.push_back(rdata);
                got_resp.push_back(rresp);
                got_id.push_back(rid);
                got_last.push_back(rlast);
                if (rlast) done = 1'b1;
            end
            stalled = !rready;
            snap    = {rid, rdata, rresp, rlast};
        end
        if (!done) chk("burst_completed_in_budget", 0, 1);
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_low_after_last", rvalid, 0);
        chk("arready_after_last", arready, 1);
    endtask

    task automatic check_model(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                               input logic [1:0] bt, input logic [3:0] id);
        int          n;
        logic [31:0] ed;
        logic [1:0]  er;
        n = int'(len) + 1;
        chk("beat_count", got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            exp_beat(a, len, sz, bt, i, ed, er);
            chk($sformatf("model_data[%0d]", i), got_data[i], ed);
            chk($sformatf("model_resp[%0d]", i), got_resp[i], er);
            chk($sformatf("model_rid[%0d]", i), got_id[i], id);
            chk($sformatf("model_rlast[%0d]", i), got_last[i], (i == n - 1));
        end
    endtask

    // Global watchdog so the run always ends
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, old;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;
        logic [3:0]  ri;
        int          w;

        sys_rstn = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0;
        arburst = '0; arid = '0; rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        sys_rstn = 1'b1;
        @(negedge clk);
        chk("arready_after_release", arready, 1);
        chk("rvalid_after_release", rvalid, 0);

        // ---------------- preload: word i = (i+1)*0x11 ----------------
        for (int i = 0; i < 256; i++) begin
            mem_we = 1'b1; mem_waddr = 8'(i); mem_wdata = 32'(i + 1) * 32'h11;
            model_mem[i] = 32'(i + 1) * 32'h11;
            @(negedge clk);
        end
        mem_we = 1'b0;

        // ---------------- directed table ----------------
        vecs[0]  = mk(32'h0,        8'd3, 3'd2, 2'b01, 4'h5, 4, 32'h11, 32'h22, 32'h33, 32'h44, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[1]  = mk(32'h8,        8'd3, 3'd2, 2'b10, 4'h3, 4, 32'h33, 32'h44, 32'h11, 32'h22, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[2]  = mk(32'h8,        8'd2, 3'd2, 2'b10, 4'h2, 3, 32'h0,  32'h0,  32'h0,  32'h0,  2'd2, 2'd2, 2'd2, 2'd0);
        vecs[3]  = mk(32'h3F8,      8'd3, 3'd2, 2'b01, 4'h1, 4, 32'h10EF, 32'h1100, 32'h0, 32'h0, 2'd0, 2'd0, 2'd3, 2'd3);
        vecs[4]  = mk(32'h4,        8'd2, 3'd2, 2'b00, 4'h6, 3, 32'h22, 32'h22, 32'h22, 32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        vecs[5]  = mk(32'h10,       8'd0, 3'd2, 2'b01, 4'hF, 1, 32'h55, 32'h0,  32'h0,  32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        vecs[6]  = mk(32'h0,        8'd1, 3'd3, 2'b01, 4'h7, 2, 32'h0,  32'h0,  32'h0,  32'h0,  2'd2, 2'd2, 2'd0, 2'd0);
        vecs[7]  = mk(32'h0,        8'd0, 3'd2, 2'b11, 4'h8, 1, 32'h0,  32'h0,  32'h0,  32'h0,  2'd2, 2'd0, 2'd0, 2'd0);
        vecs[8]  = mk(32'h2,        8'd3, 3'd0, 2'b01, 4'h9, 4, 32'h11, 32'h11, 32'h22, 32'h22, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[9]  = mk(32'h1C,       8'd1, 3'd2, 2'b10, 4'hA, 2, 32'h88, 32'h77, 32'h0,  32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        vecs[10] = mk(32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 4'hB, 2, 32'h0,  32'h11, 32'h0,  32'h0,  2'd3, 2'd0, 2'd0, 2'd0);
        vecs[11] = mk(32'h34,       8'd7, 3'd1, 2'b10, 4'hC, 8, 32'hEE, 32'hEE, 32'hFF, 32'hFF, 2'd0, 2'd0, 2'd0, 2'd0);

        for (int v = 0; v < 12; v++) begin
            do_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id, 0);
            chk($sformatf("vec%0d_count", v), got_data.size(), vecs[v].nbeats);
            for (int i = 0; i < 4 && i < vecs[v].nbeats && i < got_data.size(); i++) begin
                chk($sformatf("vec%0d_data[%0d]", v, i), got_data[i], vecs[v].data[i]);
                chk($sformatf("vec%0d_resp[%0d]", v, i), got_resp[i], vecs[v].resp[i]);
            end
            check_model(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id);
        end

        // ---------------- stalled burst, rready 1,0,0,... ----------------
        do_burst(32'h0, 8'd3, 3'd2, 2'b01, 4'h5, 1);
        check_model(32'h0, 8'd3, 3'd2, 2'b01, 4'h5);

        // ---------------- FIXED with same-edge write to the read word ----------------
        @(negedge clk);
        araddr = 32'h4; arlen = 8'd2; arsize = 3'd2; arburst = 2'b00; arid = 4'h6;
        arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        old = model_mem[1];
        chk("fixed_beat0", rdata, old);
        mem_we = 1'b1; mem_waddr = 8'd1; mem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_we = 1'b0;
        chk("fixed_beat1_old", rdata, old);
        chk("fixed_beat1_rlast", rlast, 0);
        @(negedge clk);
        chk("fixed_beat2_new", rdata, 32'hDEADBEEF);
        chk("fixed_beat2_rlast", rlast, 1);
        model_mem[1] = 32'hDEADBEEF;
        @(negedge clk);
        rready = 1'b0;
        chk("fixed_done_rvalid", rvalid, 0);

        // ---------------- reset in the middle of an 8-beat burst ----------------
        @(negedge clk);
        araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'h4;
        arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_beat2", rdata, model_mem[2]);
        sys_rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_rlast", rlast, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_rid", rid, 0);
        sys_rstn = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("rst_mid_arready", arready, 1);
        chk("rst_mid_no_more_beats", rvalid, 0);
        do_burst(32'h20, 8'd3, 3'd2, 2'b01, 4'h2, 0);
        check_model(32'h20, 8'd3, 3'd2, 2'b01, 4'h2);

        // ---------------- random bursts against the model ----------------
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom_range(0, 255);
                @(negedge clk);
                mem_we = 1'b1; mem_waddr = 8'(w); mem_wdata = $urandom;
                model_mem[w] = mem_wdata;
                @(negedge clk);
                mem_we = 1'b0;
            end
            case ($urandom_range(0, 3))
                0:       ra = 32'($urandom_range(0, 32'h3FF));
                1:       ra = 32'h380 + 32'($urandom_range(0, 32'hBF));
                2:       ra = 32'hFFFFFFC0 + 32'($urandom_range(0, 63));
                default: ra = $urandom;
            endcase
            rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rb = 2'($urandom_range(0, 3));
            if (rb == 2'b10 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0:       rl = 8'd1;
                    1:       rl = 8'd3;
                    2:       rl = 8'd7;
                    default: rl = 8'd15;
                endcase
            end else begin
                rl = 8'($urandom_range(0, 15));
            end
            ri = 4'($urandom_range(0, 15));
            do_burst(ra, rl, rs, rb, ri, 2);
            check_model(ra, rl, rs, rb, ri);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
